// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the UART transmit and receive engines:
//   - uart_state_e   : frame FSM states (IDLE, START, DATA, STOP)
//   - UART_DATA_BITS : payload bits per frame (8N1 framing)
//   - clks_per_bit() : system clocks per line bit (integer division)
//   - cnt_width()    : counter width for a count of n, never below 1 bit
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // $clog2(1) is 0, which would give a zero-width counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
// Bit-period divider. While en_i is high it produces a one-cycle tick_o
// every CLKS_PER_BIT cycles. The first tick comes CLKS_PER_BIT cycles after
// en_i rises. While en_i is low the counter is held at zero.
// Ports:
//   clk_i  : system clock
//   rst_i  : synchronous, active-high reset
//   en_i   : count enable
//   tick_o : high in the last cycle of each bit period
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = cnt_width(CLKS_PER_BIT)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    // Wrap to zero on every tick so each bit period starts from a clean count.
    always_comb begin
        if (!en_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine
// 8N1 UART transmitter. When tx_start is high in IDLE, the block latches
// tx_data and sends a frame on UART_TX. The frame is a start bit (0), eight
// data bits LSB first, and a stop bit (1). Each line level is held for
// CLKS_PER_BIT = CLK_FREQ/BAUD clocks.
// Ports:
//   sysclk   : system clock, rising edge
//   reset    : synchronous, active-high; aborts any frame in flight
//   tx_data  : byte to send, sampled only at the accept edge
//   tx_start : level request; ignored outside IDLE
//   UART_TX  : registered serial line, idle high
//   tx_busy  : high from the accept edge until the return to IDLE
//   tx_done  : one-cycle pulse in the last cycle of the stop bit
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       UART_TX,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = cnt_width(CLKS_PER_BIT);
    localparam int BIT_IDX_W    = $clog2(UART_DATA_BITS);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(UART_DATA_BITS - 1);

    uart_state_e               state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic                      tx_q, tx_d;
    logic                      bit_tick;

    // The divider runs only while a frame is in progress, so it stays at
    // zero in IDLE and every frame starts with a full-length start bit.
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud_tick (
        .clk_i  (sysclk),
        .rst_i  (reset),
        .en_i   (state_q != IDLE),
        .tick_o (bit_tick)
    );

    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_done   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d   = START;
                    shift_d   = tx_data;
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d   = STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_d = IDLE;
                    // An edge that resets instead of completing the frame
                    // must not announce completion.
                    tx_done = !reset;
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is computed from the next state so the registered
        // output changes on the same edge as the state, one cycle after accept.
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
        end
    end

    assign UART_TX = tx_q;
    assign tx_busy = (state_q != IDLE);

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz, SHALL be provided.
REQ-002 Parameter BAUD, default 9600, line bit rate in bit/s, SHALL be provided.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 sysclk  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tx_data  input  8  byte to send, sampled only at the accept edge.
REQ-007 tx_start  input  1  level request to send tx_data.
REQ-008 UART_TX  output  1  serial line, idle high, registered.
REQ-009 tx_busy  output  1  high from the accept edge until the frame completes.
REQ-010 tx_done  output  1  one-cycle pulse marking the end of the stop bit.

Function
REQ-011 Derived constant CLKS_PER_BIT = CLK_FREQ/BAUD (integer division) SHALL set every bit period; the bit counter width SHALL be $clog2(CLKS_PER_BIT).
REQ-012 Frame SHALL be 8N1: one start bit (0), eight data bits LSB first, true polarity (no inversion on the line), one stop bit (1).
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE->START on tx_start=1.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->STOP after 8 bit periods.
- STOP->IDLE after CLKS_PER_BIT cycles.
REQ-014 Accept: tx_start=1 while in IDLE SHALL latch tx_data into a shift register and set tx_busy=1 at the same edge.
REQ-015 UART_TX SHALL drive 0 starting the cycle after the accept edge, i.e. one cycle of latency.
REQ-016 Each line level SHALL be held for exactly CLKS_PER_BIT cycles.
- The full frame SHALL occupy 10*CLKS_PER_BIT cycles from the first start-bit cycle.
REQ-017 tx_start SHALL be ignored while not in IDLE.
- Changes on tx_data during a frame SHALL NOT affect the frame in flight.
REQ-018 In the last cycle of STOP, tx_done SHALL be 1 for exactly one cycle.
- tx_busy SHALL fall at the following edge, together with the return to IDLE.
REQ-019 Back-to-back: tx_start held high SHALL be accepted in the first IDLE cycle.
- The gap between frames SHALL be exactly one IDLE cycle of line-high, on top of the stop bit.
REQ-020 The divisor counter SHALL reset to 0 at every bit boundary.
- The counter SHALL NOT run in IDLE.

Reset
REQ-021 At reset, state SHALL be IDLE, UART_TX=1, tx_busy=0, tx_done=0, and the counters and shift register SHALL be 0.
REQ-022 Reset asserted mid-frame SHALL abort the frame.
- UART_TX SHALL be 1 at the first edge with reset=1.
- No tx_done SHALL be issued for the aborted frame.
REQ-023 Reset SHALL take priority over tx_start in the same cycle.

Structure
REQ-024 A shared package uart_pkg SHALL hold:
- the FSM state typedef (IDLE, START, DATA, STOP);
- UART_DATA_BITS=8;
- the CLKS_PER_BIT derivation function.
The same package SHALL be reused by the receive side.
REQ-025 A single sub-module uart_baud_tick SHALL generate a one-cycle tick every CLKS_PER_BIT cycles while enabled, and SHALL clear when disabled.

Verification (CLK_FREQ=16, BAUD=1, so CLKS_PER_BIT=16, unless stated)
REQ-026 Reset, then idle 50 cycles -> UART_TX=1, tx_busy=0, tx_done=0 throughout.
REQ-027 Send 0x55 -> line sequence 0,1,0,1,0,1,0,1,0,1, each held 16 cycles.
- tx_done pulses once at cycle 160 after the first start cycle.
REQ-028 Send 0xA3 with tx_data changed to 0xFF and tx_start pulsed again mid-frame -> line carries 0,1,1,0,0,0,1,0,1,1.
- No second frame is sent.
REQ-029 tx_start held high with 0x00 then 0xFF -> two frames separated by exactly one idle-high cycle after the stop bit.
- tx_done fires twice.
REQ-030 Reset asserted in DATA bit 3 of 0x0F -> UART_TX=1 and tx_busy=0 at the next edge.
- No tx_done is issued.
- A new 0x81 frame afterwards is bit-exact.
REQ-031 Default parameters, send 0xC4 -> each bit is 10416 cycles long, measured on the falling edge of the start bit.
